combo_checker: RTL and testbench

COMBO_CHECKER -- requirements
Module: combo_checker

---
 rtl/combo_checker.sv | 166 ++++++++++++++++
 tb/tb_combo_checker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_checker.sv
// combo_checker
// Four-digit combination lock checker. Digits arrive from an up/down digit
// counter and are captured one per press of a debounced enter button. A full
// entry equal to CODE opens the lock for UNLOCK_CYCLES cycles; MAX_TRIES wrong
// entries in a row raise the alarm for LOCKOUT_CYCLES cycles.
//
// Ports:
//   clk        in   1  sole clock, all state updates on the rising edge
//   rst        in   1  asynchronous active-high reset
//   digit      in   4  current digit counter value
//   enter      in   1  debounced enter button level
//   clear      in   1  aborts a partial entry, or relocks early while open
//   unlocked   out  1  registered, high while the lock is open
//   alarm      out  1  registered, high while locked out
//   digit_idx  out  2  digits captured so far in the current entry (0..3)
//   fails      out  2  consecutive wrong-entry count

module combo_checker #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 8,
    parameter int          LOCKOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] digit_idx,
    output logic [1:0] fails
);

    // The timer only ever counts down from one of the two load values, so it
    // needs just enough bits for the larger of them.
    localparam int TIMER_MAX = ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES) - 1;
    localparam int TW        = (TIMER_MAX < 1) ? 1 : $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

    // A wrong entry while fails is below LAST_SAFE only bumps the count;
    // at LAST_SAFE it is the final allowed miss and trips the lockout.
    localparam logic [1:0] FAILS_LIMIT = 2'(MAX_TRIES);
    localparam logic [1:0] LAST_SAFE   = 2'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [1:0]    idx_n, fails_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    buf0, buf1, buf2;
    logic [3:0]    buf0_n, buf1_n, buf2_n;
    logic          enter_q;
    logic          press;

    // A press is only the rising edge of the enter level. Because enter_q is
    // tracked in every state, a button held through OPEN or LOCKOUT cannot
    // look like a fresh press when the lock returns to ENTRY.
    assign press = enter & ~enter_q;

    // State register plus everything the next-state logic decides. The two
    // status outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENTRY;
            digit_idx <= 2'd0;
            fails     <= 2'd0;
            timer     <= '0;
            buf0      <= 4'd0;
            buf1      <= 4'd0;
            buf2      <= 4'd0;
            enter_q   <= 1'b0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            digit_idx <= idx_n;
            fails     <= fails_n;
            timer     <= timer_n;
            buf0      <= buf0_n;
            buf1      <= buf1_n;
            buf2      <= buf2_n;
            enter_q   <= enter;
            unlocked  <= (state_n == OPEN);
            alarm     <= (state_n == LOCKOUT);
        end
    end

    // Next-state logic. In ENTRY the first three presses fill the buffer and
    // the fourth is compared together with the live digit, so the verdict
    // lands on the same edge as the last press. Clear outranks a press. In
    // OPEN, clear and timer expiry both simply relock. LOCKOUT ignores all
    // inputs and only runs out its timer, forgiving the misses on exit.
    always_comb begin
        state_n = state;
        idx_n   = digit_idx;
        fails_n = fails;
        timer_n = timer;
        buf0_n  = buf0;
        buf1_n  = buf1;
        buf2_n  = buf2;

        case (state)
            ENTRY: begin
                if (clear) begin
                    idx_n = 2'd0;
                end else if (press) begin
                    if (digit_idx != 2'd3) begin
                        case (digit_idx)
                            2'd0:    buf0_n = digit;
                            2'd1:    buf1_n = digit;
                            default: buf2_n = digit;
                        endcase
                        idx_n = digit_idx + 2'd1;
                    end else begin
                        idx_n = 2'd0;
                        if ({buf0, buf1, buf2, digit} == CODE) begin
                            state_n = OPEN;
                            fails_n = 2'd0;
                            timer_n = UNLOCK_LOAD;
                        end else if (fails < LAST_SAFE) begin
                            fails_n = fails + 2'd1;
                        end else begin
                            state_n = LOCKOUT;
                            fails_n = FAILS_LIMIT;
                            timer_n = LOCKOUT_LOAD;
                        end
                    end
                end
            end

            OPEN: begin
                if (clear || (timer == '0)) begin
                    state_n = ENTRY;
                    timer_n = '0;
                end else begin
                    timer_n = timer - TIMER_ONE;
                end
            end

            LOCKOUT: begin
                if (timer == '0) begin
                    state_n = ENTRY;
                    fails_n = 2'd0;
                end else begin
                    timer_n = timer - TIMER_ONE;
                end
            end

            default: begin
                state_n = ENTRY;
                idx_n   = 2'd0;
                timer_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_combo_checker.sv
// tb_combo_checker
// Self-checking bench for combo_checker with default parameters. A behavioural
// model tracks the lock as a mode, a queue of entered digits, a miss count and
// a count of remaining open/alarm cycles; a compare process checks all four
// outputs against it after every rising edge. Directed sequences with literal
// expectations are followed by a long randomized run.

module tb_combo_checker;

    localparam logic [15:0] CODE           = 16'h1234;
    localparam int          MAX_TRIES      = 3;
    localparam int          UNLOCK_CYCLES  = 8;
    localparam int          LOCKOUT_CYCLES = 32;

    localparam int MODE_ENTRY   = 0;
    localparam int MODE_OPEN    = 1;
    localparam int MODE_LOCKOUT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       unlocked;
    logic       alarm;
    logic [1:0] digit_idx;
    logic [1:0] fails;

    int errorCount = 0;
    int checkCount = 0;
    bit compareOn  = 1'b0;

    combo_checker #(
        .CODE          (CODE),
        .MAX_TRIES     (MAX_TRIES),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .digit    (digit),
        .enter    (enter),
        .clear    (clear),
        .unlocked (unlocked),
        .alarm    (alarm),
        .digit_idx(digit_idx),
        .fails    (fails)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Central comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state: what mode the lock is in, which digits have been
    // keyed so far, how many misses in a row, and how many more cycles the
    // open or alarm condition still has to last.
    int         mMode      = MODE_ENTRY;
    logic [3:0] entered[$];
    int         mFails     = 0;
    int         mRemaining = 0;
    bit         mPrevEnter = 1'b0;
    bit         mPressed;
    logic [15:0] mAttempt;

    // Behavioural model, advanced on each rising edge from the inputs that
    // were stable before it; reset wipes it straight away.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mMode = MODE_ENTRY;
            entered.delete();
            mFails = 0;
            mRemaining = 0;
            mPrevEnter = 1'b0;
        end else begin
            mPressed   = enter && !mPrevEnter;
            mPrevEnter = enter;
            if (mMode == MODE_ENTRY) begin
                if (clear) begin
                    entered.delete();
                end else if (mPressed) begin
                    entered.push_back(digit);
                    if (entered.size() == 4) begin
                        mAttempt = {entered[0], entered[1], entered[2], entered[3]};
                        entered.delete();
                        if (mAttempt == CODE) begin
                            mMode = MODE_OPEN;
                            mRemaining = UNLOCK_CYCLES;
                            mFails = 0;
                        end else begin
                            mFails++;
                            if (mFails >= MAX_TRIES) begin
                                mMode = MODE_LOCKOUT;
                                mRemaining = LOCKOUT_CYCLES;
                            end
                        end
                    end
                end
            end else if (mMode == MODE_OPEN) begin
                mRemaining--;
                if (clear || mRemaining == 0) mMode = MODE_ENTRY;
            end else begin
                mRemaining--;
                if (mRemaining == 0) begin
                    mMode = MODE_ENTRY;
                    mFails = 0;
                end
            end
        end
    end

    // Compare process: one step after every rising edge, all outputs against
    // the model.
    always @(posedge clk) begin
        #1;
        if (compareOn) begin
            checkOutput("unlocked", int'(unlocked), int'(mMode == MODE_OPEN));
            checkOutput("alarm", int'(alarm), int'(mMode == MODE_LOCKOUT));
            checkOutput("digit_idx", int'(digit_idx), entered.size());
            checkOutput("fails", int'(fails), mFails);
        end
    end

    // Inputs change only on falling edges, away from the sampling edge.
    task automatic applyStimulus(input logic [3:0] d, input logic e, input logic c);
        @(negedge clk);
        digit = d;
        enter = e;
        clear = c;
    endtask

    task automatic pressDigit(input logic [3:0] d);
        applyStimulus(d, 1'b1, 1'b0);
        applyStimulus(d, 1'b0, 1'b0);
    endtask

    task automatic enterCode(input logic [15:0] code);
        for (int i = 0; i < 4; i++) pressDigit(code[15 - 4*i -: 4]);
    endtask

    // Counts how many consecutive cycles the chosen output stays high,
    // starting from the current one; bounded so a stuck output still ends.
    task automatic measureHigh(input bit watchAlarm, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (watchAlarm ? alarm : unlocked) n++;
            else break;
            applyStimulus(digit, 1'b0, 1'b0);
        end
    endtask

    // Raises reset mid-cycle, checks the outputs collapse without any clock
    // edge, then releases it on the next falling edge.
    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput({tag, " unlocked"}, int'(unlocked), 0);
        checkOutput({tag, " alarm"}, int'(alarm), 0);
        checkOutput({tag, " digit_idx"}, int'(digit_idx), 0);
        checkOutput({tag, " fails"}, int'(fails), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hard time limit so the bench always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int n;
    logic [15:0] codeVar;
    int sel;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset unlocked", int'(unlocked), 0);
        checkOutput("reset alarm", int'(alarm), 0);
        checkOutput("reset digit_idx", int'(digit_idx), 0);
        checkOutput("reset fails", int'(fails), 0);
        compareOn = 1'b1;
        rst = 1'b0;

        // Correct code opens for exactly eight cycles.
        pressDigit(4'd1);
        checkOutput("idx after 1", int'(digit_idx), 1);
        pressDigit(4'd2);
        checkOutput("idx after 2", int'(digit_idx), 2);
        pressDigit(4'd3);
        checkOutput("idx after 3", int'(digit_idx), 3);
        pressDigit(4'd4);
        checkOutput("idx after 4", int'(digit_idx), 0);
        checkOutput("open unlocked", int'(unlocked), 1);
        checkOutput("open fails", int'(fails), 0);
        measureHigh(1'b0, n);
        checkOutput("unlock length", n, 8);

        // Two misses then a hit.
        enterCode(16'h1235);
        checkOutput("fails after miss 1", int'(fails), 1);
        enterCode(16'h1235);
        checkOutput("fails after miss 2", int'(fails), 2);
        checkOutput("no alarm after 2", int'(alarm), 0);
        checkOutput("still locked", int'(unlocked), 0);
        enterCode(16'h1234);
        checkOutput("open after misses", int'(unlocked), 1);
        checkOutput("fails cleared", int'(fails), 0);
        measureHigh(1'b0, n);
        checkOutput("unlock length 2", n, 8);

        // Three misses: alarm for 32 cycles despite presses and clears, with
        // enter held high across the exit.
        enterCode(16'h1235);
        enterCode(16'h0000);
        enterCode(16'hFFFF);
        checkOutput("alarm on", int'(alarm), 1);
        checkOutput("fails at limit", int'(fails), 3);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'(i), (i < 12) ? i[0] : 1'b1, i[1]);
            if (!alarm) break;
            n++;
        end
        checkOutput("alarm length", n, 32);
        applyStimulus(4'd1, 1'b1, 1'b0);
        checkOutput("held enter no press", int'(digit_idx), 0);
        checkOutput("fails after lockout", int'(fails), 0);
        applyStimulus(4'd0, 1'b0, 1'b0);

        // Clear wins over a simultaneous press and keeps the miss count.
        enterCode(16'h9999);
        pressDigit(4'd1);
        pressDigit(4'd2);
        checkOutput("idx before clear", int'(digit_idx), 2);
        applyStimulus(4'd7, 1'b1, 1'b1);
        applyStimulus(4'd7, 1'b0, 1'b0);
        checkOutput("idx after clear", int'(digit_idx), 0);
        checkOutput("fails kept by clear", int'(fails), 1);
        enterCode(16'h1234);
        checkOutput("open after clear", int'(unlocked), 1);
        measureHigh(1'b0, n);

        // Held enter counts once; clear during OPEN relocks on the next edge.
        for (int i = 0; i < 20; i++) applyStimulus(4'd1, 1'b1, 1'b0);
        checkOutput("held enter idx", int'(digit_idx), 1);
        applyStimulus(4'd1, 1'b0, 1'b0);
        pressDigit(4'd2);
        pressDigit(4'd3);
        pressDigit(4'd4);
        checkOutput("open after hold", int'(unlocked), 1);
        applyStimulus(4'd0, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b1);
        checkOutput("open before clear edge", int'(unlocked), 1);
        applyStimulus(4'd0, 1'b0, 1'b0);
        checkOutput("relocked by clear", int'(unlocked), 0);

        // Asynchronous reset from OPEN and from LOCKOUT.
        enterCode(16'h1234);
        checkOutput("open before reset", int'(unlocked), 1);
        asyncReset("rst in open");
        enterCode(16'h0001);
        enterCode(16'h0002);
        enterCode(16'h0003);
        checkOutput("alarm before reset", int'(alarm), 1);
        asyncReset("rst in lockout");
        pressDigit(4'd1);
        checkOutput("press after reset", int'(digit_idx), 1);
        applyStimulus(4'd0, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0);

        // Randomized run, biased toward the correct digit so opens happen.
        codeVar = CODE;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                asyncReset("random reset");
            end else begin
                sel = entered.size();
                if (mMode == MODE_ENTRY && $urandom_range(0, 9) < 8)
                    applyStimulus(codeVar[15 - 4*sel -: 4], 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 39) == 0));
                else
                    applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 39) == 0));
            end
        end

        applyStimulus(4'd0, 1'b0, 1'b0);
        compareOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
